// File: rtl/echo_emulator.sv
// Ultrasonic ranging sensor stand-in: accepts a trigger pulse and answers
// with an echo pulse whose width is a programmable distance count.
module echo_emulator #(
    parameter int WIDTH        = 24,
    parameter int TRIG_MIN     = 500,
    parameter int DELAY        = 1000,
    parameter int ECHO_MAX     = 1900000,
    parameter int HOLDOFF      = 500,
    parameter int DEFAULT_DIST = 900
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trigger_i,
    output logic             echo_o,
    input  logic [WIDTH-1:0] dist_i,
    input  logic             dist_valid_i,
    output logic             dist_ready_o,
    output logic             busy_o,
    output logic             trig_err_o
);

    localparam int TW = $clog2(TRIG_MIN + 1);

    localparam logic [TW-1:0]    TRIG_MIN_C = TW'(TRIG_MIN);
    localparam logic [WIDTH-1:0] ECHO_MAX_C = WIDTH'(ECHO_MAX);
    localparam logic [WIDTH-1:0] DELAY_M1   = WIDTH'(DELAY - 1);
    localparam logic [WIDTH-1:0] HOLD_M1    = WIDTH'(HOLDOFF - 1);
    localparam logic [WIDTH-1:0] DEFAULT_C  = WIDTH'(DEFAULT_DIST);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_DLY,
        S_ECHO,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [TW-1:0]    r_trig_cnt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_dist_q;
    logic [WIDTH-1:0] r_len_q;
    logic             r_armed;
    logic             r_echo;
    logic             r_busy;
    logic             r_err;
    logic             r_ready;
    logic             w_accept;

    // A zero or out-of-range distance means "no object": answer with the maximum echo.
    function automatic logic [WIDTH-1:0] clamp_len(input logic [WIDTH-1:0] d);
        return ((d == '0) || (d > ECHO_MAX_C)) ? ECHO_MAX_C : d;
    endfunction

    assign w_accept     = dist_valid_i && r_ready;
    assign echo_o       = r_echo;
    assign busy_o       = r_busy;
    assign trig_err_o   = r_err;
    assign dist_ready_o = r_ready;

    // Measurement FSM; all outputs are registered alongside the state so echo_o never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_trig_cnt <= '0;
            r_cnt      <= '0;
            r_dist_q   <= DEFAULT_C;
            r_len_q    <= '0;
            r_armed    <= 1'b0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_err <= 1'b0;
            // A load on the TRIG->DLY cycle lands here while the snapshot below reads the old value.
            if (w_accept) begin
                r_dist_q <= dist_i;
            end
            case (r_state)
                S_IDLE: begin
                    // A trigger must be seen low before it can start a measurement.
                    if (!trigger_i) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state    <= S_TRIG;
                        r_trig_cnt <= TW'(1);
                    end
                end
                S_TRIG: begin
                    if (trigger_i) begin
                        if (r_trig_cnt < TRIG_MIN_C) begin
                            r_trig_cnt <= r_trig_cnt + 1'b1;
                        end
                    end else if (r_trig_cnt >= TRIG_MIN_C) begin
                        r_len_q    <= clamp_len(r_dist_q);
                        r_cnt      <= DELAY_M1;
                        r_trig_cnt <= '0;
                        r_state    <= S_DLY;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                    end else begin
                        r_err      <= 1'b1;
                        r_trig_cnt <= '0;
                        r_state    <= S_IDLE;
                        r_armed    <= 1'b1;
                    end
                end
                S_DLY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_ECHO;
                        r_echo  <= 1'b1;
                        r_cnt   <= r_len_q - 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_ECHO: begin
                    if (r_cnt == '0) begin
                        r_state <= S_HOLD;
                        r_echo  <= 1'b0;
                        r_cnt   <= HOLD_M1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    // Disarm so a trigger still high from the last cycle cannot retrigger.
                    if (r_cnt == '0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_armed <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_armed <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/echo_emulator.md
# echo_emulator

Synthesizable responder for the ultrasonic ranging protocol: it receives the trigger pulse and returns an echo pulse whose width equals a programmed distance count. This lets the slicer's supersonic path and the controller's distance loop run on the board or in simulation without the physical sensor. It sits between the `trigger_o`/`echo_i` pins of the design under test and a stimulus source, such as a bench or switch logic, that loads the echo length.

## Interface
- `WIDTH`, 24: width of the echo-length counter and `dist_i`.
- `TRIG_MIN`, 500: minimum trigger high time in cycles for a valid trigger (10 us at 50 MHz).
- `DELAY`, 1000: cycles from trigger acceptance to the echo rising edge. Models the burst time.
- `ECHO_MAX`, 1900000: echo width in cycles for "no object" (38 ms at 50 MHz).
- `HOLDOFF`, 500: dead cycles after the echo falls before the next trigger is armed.
- `DEFAULT_DIST`, 900: echo length loaded by reset.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous reset, active-high.
- `trigger_i`, in, 1: trigger from the ranging initiator. Same clock domain.
- `echo_o`, out, 1: echo pulse, registered.
- `dist_i`, in, WIDTH: echo length in cycles for the next measurement.
- `dist_valid_i`, in, 1: `dist_i` is offered.
- `dist_ready_o`, out, 1: `dist_i` is accepted on a cycle where `dist_valid_i && dist_ready_o`.
- `busy_o`, out, 1: a measurement is in progress (DELAY, ECHO or HOLD).
- `trig_err_o`, out, 1: one-cycle pulse when a trigger was shorter than `TRIG_MIN`.

## Operation
- The FSM has five states: IDLE, TRIG, DLY, ECHO, HOLD. Encoding is free.
- **Registers:** state, `trig_cnt` (saturating at `TRIG_MIN`), phase counter (WIDTH bits), `dist_q` (shadow), `len_q` (snapshot), `armed` flag.
- **IDLE:**
  - If `trigger_i` is 0, set `armed`=1.
  - If `armed` and `trigger_i`=1, go to TRIG with `trig_cnt`=1.
  - A trigger that is already high when IDLE is entered is ignored until it has been seen low.
- **TRIG:**
  - While `trigger_i`=1, `trig_cnt` increments and saturates at `TRIG_MIN`. A trigger stuck high keeps the block in TRIG indefinitely.
  - On the first cycle with `trigger_i`=0:
    - If `trig_cnt >= TRIG_MIN`: snapshot `len_q` = (`dist_q`==0 or `dist_q`>`ECHO_MAX`) ? `ECHO_MAX` : `dist_q`. Load the phase counter and go to DLY.
    - Otherwise: pulse `trig_err_o` for that cycle, go to IDLE, set `armed`=1.
- **DLY:** count `DELAY` cycles, then go to ECHO.
- **ECHO:** `echo_o`=1 for exactly `len_q` cycles, then go to HOLD.
- **HOLD:** count `HOLDOFF` cycles, then go to IDLE with `armed`=0.
- **Distance handshake:**
  - `dist_ready_o` = (state is IDLE or TRIG).
  - On accept, `dist_q` <= `dist_i`. Acceptance takes effect the same cycle.
  - A load accepted on the same cycle as the TRIG->DLY decision is not used. That measurement uses the old `dist_q`; the new value applies to the next measurement.
- **Trigger edges while busy:** all `trigger_i` activity in DLY, ECHO and HOLD is ignored.
- **Reset:** overrides everything on the next edge, including mid-echo. State=IDLE, `armed`=0, `dist_q`=`DEFAULT_DIST`, all counters 0.
- **Output reset values:** `echo_o`=0, `busy_o`=0, `trig_err_o`=0, `dist_ready_o`=1 (it follows IDLE).

## Timing
- Let edge E be the first rising edge at which `trigger_i` is sampled 0 after a valid high period.
  - `busy_o` rises after E.
  - `echo_o` rises after edge E+`DELAY`.
  - `echo_o` falls after edge E+`DELAY`+`len_q`.
  - `busy_o` falls after edge E+`DELAY`+`len_q`+`HOLDOFF`.
- Trigger acceptance counts cycles sampled high: `TRIG_MIN` high cycles are accepted, `TRIG_MIN`-1 are rejected.
- `trig_err_o` is registered. It is high for exactly the one cycle following the rejecting edge.
- `echo_o` is glitch-free: driven from a flop, never from combinational state decode.

## Test plan
1. **Reset values.** Assert `rst` for 2 cycles -> `echo_o`=0, `busy_o`=0, `dist_ready_o`=1, `trig_err_o`=0. Then trigger 500 cycles with no load -> echo high for exactly 900 cycles, starting 1000 cycles after the falling edge.
2. **Sequence of loads.** Load `dist_i`=600, 350, 910 before successive 500-cycle triggers -> echo widths of 600, 350 and 910 cycles. `busy_o` low for at least 500 cycles between measurements.
3. **Trigger length boundary.** Trigger 499 cycles -> one `trig_err_o` pulse, no echo. Trigger 500 cycles -> echo. Trigger held 5000 cycles -> echo begins 1000 cycles after release.
4. **Busy and arming.** Trigger pulses during DLY, ECHO and HOLD -> ignored, no extra echo. Trigger held high across HOLD->IDLE -> no measurement until it goes low and high again.
5. **Distance limits.** `dist_i`=0 and `dist_i`=2000000 -> echo width 1900000 (`ECHO_MAX`). `dist_i`=1 -> echo width 1 cycle.
6. **Mid-operation events.**
   - Assert `rst` mid-echo -> `echo_o` low after the next edge, `busy_o`=0, `dist_q`=900.
   - Load on the TRIG->DLY decision cycle -> the current echo uses the old length, the next echo uses the new one.
